// File: rtl/io_map_pkg.sv
// io_map_pkg: IO offsets and event-vector layout shared by the input conditioner
package io_map_pkg;
  localparam logic [2:0] IO_OFS_SW   = 3'b001;
  localparam logic [2:0] IO_OFS_BTN  = 3'b010;
  localparam logic [2:0] IO_OFS_EVT  = 3'b011;
  localparam logic [2:0] IO_OFS_MASK = 3'b100;
  localparam int EVT_WIDTH   = 21;
  localparam int EVT_BTN_LSB = 0;
  localparam int EVT_SW_LSB  = 5;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchroniser, tick-sampled history and clean level for one input
module debounce_bit #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic tick_i,
  output logic clean_o
);
  logic [1:0]                sync_q;
  logic [STABLE_SAMPLES-1:0] hist_q;
  logic                      clean_q, clean_d;

  // accept a new level only once the whole history agrees
  always_comb clean_d = (&hist_q) ? 1'b1 : (~|hist_q) ? 1'b0 : clean_q;

  // synchronise, sample on tick, then commit the qualified level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= '0;
      clean_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      if (tick_i) hist_q <= {hist_q[STABLE_SAMPLES-2:0], sync_q[1]};
      clean_q <= clean_d;
    end

  assign clean_o = clean_q;
endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: debounces SW/BTN, latches sticky edge events and serves IO reads.
// Optional INPUT_EVENT_IRQ_EN adds an irq output and a mask register at offset 100.
module io_input_conditioner
  import io_map_pkg::*;
#(
  parameter int TICK_DIV       = 100000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw_raw,
  input  logic [4:0]  btn_raw,
  input  logic [31:0] io_address,
  input  logic        io_read_en,
  input  logic        io_write_en,
  input  logic [31:0] io_write_value,
  output logic [31:0] io_read_value,
`ifdef INPUT_EVENT_IRQ_EN
  output logic        irq,
`endif
  output logic [15:0] sw_clean,
  output logic [4:0]  btn_clean
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tick;
  logic [EVT_WIDTH-1:0] raw, clean, prev_q, evt_q, evt_d, set, clr;
  logic [31:0]          rd_q, rd_d, mask_rd;
  logic [2:0]           ofs;
  logic                 unused_bits;

  assign ofs         = io_address[2:0];
  assign unused_bits = ^{io_address[31:3], io_write_value[31:EVT_WIDTH]};
  assign raw         = {sw_raw, btn_raw};

  for (genvar i = 0; i < EVT_WIDTH; i++) begin : g_db
    debounce_bit #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw[i]),
      .tick_i (tick),
      .clean_o(clean[i])
    );
  end

  assign sw_clean  = clean[EVT_SW_LSB +: 16];
  assign btn_clean = clean[EVT_BTN_LSB +: 5];

`ifdef INPUT_EVENT_IRQ_EN
  logic [EVT_WIDTH-1:0] mask_q;
  logic                 irq_q;
  assign mask_rd = {11'b0, mask_q};
  assign irq     = irq_q;

  // mask register and registered interrupt from masked sticky events
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (io_write_en && ofs == IO_OFS_MASK) mask_q <= io_write_value[EVT_WIDTH-1:0];
      irq_q <= |(evt_q & mask_q);
    end
`else
  assign mask_rd = '0;
`endif

  // tick generation, event edge detect with set-over-clear, read mux
  always_comb begin
    tick  = cnt_q == CW'(TICK_DIV - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    set   = {clean[EVT_SW_LSB +: 16] ^ prev_q[EVT_SW_LSB +: 16],
             clean[EVT_BTN_LSB +: 5] & ~prev_q[EVT_BTN_LSB +: 5]};
    clr   = (io_write_en && ofs == IO_OFS_EVT) ? io_write_value[EVT_WIDTH-1:0] : '0;
    evt_d = (evt_q & ~clr) | set;
    rd_d  = !io_read_en        ? '0 :
            ofs == IO_OFS_SW   ? {16'b0, sw_clean} :
            ofs == IO_OFS_BTN  ? {27'b0, btn_clean} :
            ofs == IO_OFS_EVT  ? {11'b0, evt_q} :
            ofs == IO_OFS_MASK ? mask_rd : '0;
  end

  // tick counter, previous clean levels, sticky events and read register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      prev_q <= '0;
      evt_q  <= '0;
      rd_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= clean;
      evt_q  <= evt_d;
      rd_q   <= rd_d;
    end

  assign io_read_value = rd_q;
endmodule
